// File: rtl/hwpe_stream_serialize_chunks_if.sv
// Valid/ready stream carrying data plus byte strobes, shared by wide and narrow sides.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH/8
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;

    modport source (output valid, output data, output strb, input ready);
    modport sink   (input valid, input data, input strb, output ready);
endinterface

// File: rtl/hwpe_stream_serialize_chunks.sv
// Buffers one wide stream word and replays it lane by lane (lane 0 first) on a narrow stream.
module hwpe_stream_serialize_chunks #(
    parameter int unsigned NB_CHUNKS      = 2,
    parameter int unsigned DATA_WIDTH_OUT = 32,
    parameter int unsigned SKIP_EMPTY     = 0
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          clear_i,
    hwpe_stream_intf_stream.sink          stream_i,
    hwpe_stream_intf_stream.source        stream_o,
    output logic                          busy_o
);
    localparam int unsigned STRB_OUT = DATA_WIDTH_OUT/8;
    localparam int unsigned IDX_W    = $clog2(NB_CHUNKS);

    typedef logic [NB_CHUNKS-1:0][DATA_WIDTH_OUT-1:0] lane_data_t;
    typedef logic [NB_CHUNKS-1:0][STRB_OUT-1:0]       lane_strb_t;

    lane_data_t         data_q;
    lane_strb_t         strb_q;
    lane_strb_t         strb_in;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   next_idx;
    logic [IDX_W-1:0]   first_idx;
    logic               full_q;
    logic               last;
    logic               empty;
    logic               oh;
    logic               ih;
    logic [NB_CHUNKS-1:0] emit_q;
    logic [NB_CHUNKS-1:0] emit_in;

    assign strb_in = stream_i.strb;

    // A lane is emitted unless skipping is enabled and its strobe is all zero.
    for (genvar l = 0; l < NB_CHUNKS; l++) begin : g_lane
        assign emit_q[l]  = (SKIP_EMPTY == 0) || (|strb_q[l]);
        assign emit_in[l] = (SKIP_EMPTY == 0) || (|strb_in[l]);
    end

    // Scan from the top lane down so the lowest qualifying index wins.
    always_comb begin
        next_idx  = '0;
        last      = 1'b1;
        first_idx = '0;
        empty     = 1'b1;
        for (int i = NB_CHUNKS-1; i >= 0; i--) begin
            if (emit_q[i] && (IDX_W'(i) > idx_q)) begin
                next_idx = IDX_W'(i);
                last     = 1'b0;
            end
            if (emit_in[i]) begin
                first_idx = IDX_W'(i);
                empty     = 1'b0;
            end
        end
    end

    assign oh             = full_q & stream_o.ready;
    assign stream_i.ready = ~full_q | (stream_o.ready & last);
    assign ih             = stream_i.valid & stream_i.ready;

    assign stream_o.valid = full_q;
    assign stream_o.data  = data_q[idx_q];
    assign stream_o.strb  = strb_q[idx_q];
    assign busy_o         = full_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            data_q <= '0;
            strb_q <= '0;
            idx_q  <= '0;
            full_q <= 1'b0;
        end else if (ih && !empty) begin
            data_q <= stream_i.data;
            strb_q <= strb_in;
            idx_q  <= first_idx;
            full_q <= 1'b1;
        end else if (ih || (oh && last)) begin
            // an accepted empty word is dropped; it can only arrive when the buffer frees up
            idx_q  <= '0;
            full_q <= 1'b0;
        end else if (oh) begin
            idx_q  <= next_idx;
        end
    end
endmodule

// File: tb/tb_hwpe_stream_serialize_chunks.sv
// Bench for the chunk serializer: a 2-lane plain instance and a 4-lane skipping instance.
module tb_hwpe_stream_serialize_chunks;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    logic busy_a, busy_b;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hwpe_stream_intf_stream #(.DATA_WIDTH(64))  in_a ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(32))  out_a ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(128)) in_b ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(32))  out_b ();

    hwpe_stream_serialize_chunks #(.NB_CHUNKS(2), .DATA_WIDTH_OUT(32), .SKIP_EMPTY(0)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
        .stream_i(in_a), .stream_o(out_a), .busy_o(busy_a));
    hwpe_stream_serialize_chunks #(.NB_CHUNKS(4), .DATA_WIDTH_OUT(32), .SKIP_EMPTY(1)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
        .stream_i(in_b), .stream_o(out_b), .busy_o(busy_b));

    typedef struct packed { logic [31:0] d; logic [3:0] s; } lane_t;
    typedef struct { logic [63:0] d; logic [7:0] s; logic [31:0] d0, d1; logic [3:0] s0, s1; } vec_t;

    lane_t sb_a[$];
    lane_t sb_b[$];
    int    hs_a[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected lanes are derived from each accepted wide word.
    always @(negedge clk) begin
        if (rst_n && !clear && in_a.valid && in_a.ready)
            for (int l = 0; l < 2; l++) sb_a.push_back({in_a.data[l*32 +: 32], in_a.strb[l*4 +: 4]});
        if (rst_n && !clear && in_b.valid && in_b.ready)
            for (int l = 0; l < 4; l++)
                if (in_b.strb[l*4 +: 4] != 4'h0) sb_b.push_back({in_b.data[l*32 +: 32], in_b.strb[l*4 +: 4]});
    end

    logic        rc_seen = 1'b0;
    logic        stall_a = 1'b0, stall_b = 1'b0;
    logic [35:0] held_a, held_b;
    always @(posedge clk) rc_seen <= !rst_n || clear;

    always @(negedge clk) begin
        lane_t e;
        if (stall_a && !rc_seen) chk("hold_a", {out_a.valid, out_a.data, out_a.strb}, {1'b1, held_a});
        if (stall_b && !rc_seen) chk("hold_b", {out_b.valid, out_b.data, out_b.strb}, {1'b1, held_b});
        if (rst_n && !clear && out_a.valid && out_a.ready) begin
            hs_a.push_back(cyc);
            if (sb_a.size() == 0) chk("sb_a_unexpected", {out_a.data, out_a.strb}, 128'hx);
            else begin e = sb_a.pop_front(); chk("sb_a_lane", {out_a.data, out_a.strb}, e); end
        end
        if (rst_n && !clear && out_b.valid && out_b.ready) begin
            if (sb_b.size() == 0) chk("sb_b_unexpected", {out_b.data, out_b.strb}, 128'hx);
            else begin e = sb_b.pop_front(); chk("sb_b_lane", {out_b.data, out_b.strb}, e); end
        end
        stall_a <= out_a.valid && !out_a.ready && rst_n && !clear;
        stall_b <= out_b.valid && !out_b.ready && rst_n && !clear;
        held_a  <= {out_a.data, out_a.strb};
        held_b  <= {out_b.data, out_b.strb};
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[4];
        logic acc_a, acc_b;
        logic [15:0] s;
        tbl[0] = '{64'hBBBBBBBB_AAAAAAAA, 8'hFF, 32'hAAAAAAAA, 32'hBBBBBBBB, 4'hF, 4'hF};
        tbl[1] = '{64'h12345678_9ABCDEF0, 8'h3C, 32'h9ABCDEF0, 32'h12345678, 4'hC, 4'h3};
        tbl[2] = '{64'h0, 8'h00, 32'h0, 32'h0, 4'h0, 4'h0};
        tbl[3] = '{64'hDEADBEEF_CAFEF00D, 8'hA5, 32'hCAFEF00D, 32'hDEADBEEF, 4'h5, 4'hA};

        in_a.valid = 0; in_a.data = '0; in_a.strb = '0; out_a.ready = 1;
        in_b.valid = 0; in_b.data = '0; in_b.strb = '0; out_b.ready = 1;
        tick(); tick();
        @(negedge clk);
        chk("rst_a_out", {out_a.valid, out_a.data, out_a.strb, busy_a, in_a.ready}, {1'b0, 32'h0, 4'h0, 1'b0, 1'b1});
        chk("rst_b_out", {out_b.valid, out_b.data, out_b.strb, busy_b, in_b.ready}, {1'b0, 32'h0, 4'h0, 1'b0, 1'b1});
        tick();
        rst_n = 1;

        // Table: single word, continuous downstream ready.
        for (int i = 0; i < 4; i++) begin
            in_a.valid = 1; in_a.data = tbl[i].d; in_a.strb = tbl[i].s;
            @(negedge clk); chk("tbl_idle_ready", in_a.ready, 1'b1);
            tick(); in_a.valid = 0;
            @(negedge clk);
            chk("tbl_lane0", {out_a.valid, out_a.data, out_a.strb, in_a.ready}, {1'b1, tbl[i].d0, tbl[i].s0, 1'b0});
            tick();
            @(negedge clk);
            chk("tbl_lane1", {out_a.valid, out_a.data, out_a.strb, in_a.ready}, {1'b1, tbl[i].d1, tbl[i].s1, 1'b1});
            tick();
            @(negedge clk); chk("tbl_drained", out_a.valid, 1'b0);
            tick();
        end

        // Back-to-back: three words, expect six handshakes in consecutive cycles.
        hs_a.delete();
        for (int w = 0; w < 3; w++) begin
            int t = 0;
            in_a.valid = 1; in_a.data = {32'hB0000000 + w, 32'hA0000000 + w}; in_a.strb = 8'hFF;
            @(negedge clk);
            while (!in_a.ready && t < 20) begin tick(); @(negedge clk); t++; end
            if (!in_a.ready) chk("b2b_accept_timeout", in_a.ready, 1'b1);
            tick();
        end
        in_a.valid = 0;
        repeat (4) tick();
        chk("b2b_count", hs_a.size(), 6);
        for (int i = 1; i < hs_a.size(); i++) chk("b2b_no_bubble", hs_a[i] - hs_a[0], i);

        // Backpressure: three stalled cycles after the first lane appears.
        out_a.ready = 0;
        in_a.valid = 1; in_a.data = 64'hBBBBBBBB_AAAAAAAA; in_a.strb = 8'hFF;
        tick(); in_a.valid = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_stall", {out_a.valid, out_a.data, in_a.ready}, {1'b1, 32'hAAAAAAAA, 1'b0});
            tick();
        end
        out_a.ready = 1;
        @(negedge clk); chk("bp_rel0", out_a.data, 32'hAAAAAAAA);
        tick();
        @(negedge clk); chk("bp_rel1", out_a.data, 32'hBBBBBBBB);
        tick();
        @(negedge clk); chk("bp_done", {out_a.valid, 32'(sb_a.size())}, {1'b0, 32'd0});
        tick();

        // Skipping of empty lanes on the 4-lane instance.
        in_b.valid = 1; in_b.data = 128'h44444444_33333333_22222222_11111111; in_b.strb = 16'h0F0F;
        tick(); in_b.valid = 0;
        @(negedge clk);
        chk("skip_l0", {out_b.valid, out_b.data, out_b.strb, in_b.ready}, {1'b1, 32'h11111111, 4'hF, 1'b0});
        tick();
        @(negedge clk);
        chk("skip_l2", {out_b.valid, out_b.data, out_b.strb, in_b.ready}, {1'b1, 32'h33333333, 4'hF, 1'b1});
        tick();
        @(negedge clk); chk("skip_done", out_b.valid, 1'b0);
        in_b.valid = 1; in_b.strb = 16'h0000;
        @(negedge clk); chk("empty_ready", in_b.ready, 1'b1);
        tick(); in_b.valid = 0;
        @(negedge clk); chk("empty_no_out", {out_b.valid, busy_b}, 2'b00);
        tick();
        in_b.valid = 1; in_b.strb = 16'hF000;
        tick(); in_b.valid = 0;
        @(negedge clk);
        chk("skip_l3", {out_b.valid, out_b.data, out_b.strb, in_b.ready}, {1'b1, 32'h44444444, 4'hF, 1'b1});
        tick();
        @(negedge clk); chk("skip_l3_done", out_b.valid, 1'b0);
        tick();

        // Clear while lane 1 is pending.
        in_a.valid = 1; in_a.data = 64'h22222222_11111111; in_a.strb = 8'hFF;
        tick(); in_a.valid = 0;
        @(negedge clk); chk("clr_lane0", out_a.data, 32'h11111111);
        tick();
        clear = 1; out_a.ready = 0;
        @(negedge clk); chk("clr_pending", {out_a.valid, out_a.data}, {1'b1, 32'h22222222});
        tick();
        clear = 0; out_a.ready = 1; sb_a.delete();
        @(negedge clk); chk("clr_after", {out_a.valid, busy_a, in_a.ready}, 3'b001);
        repeat (3) tick();

        // Random traffic with random backpressure on both instances.
        acc_a = 0; acc_b = 0;
        for (int c = 0; c < 400; c++) begin
            if (!in_a.valid || acc_a) begin
                in_a.valid = 1'($urandom_range(0, 1));
                in_a.data = {$urandom, $urandom}; in_a.strb = 8'($urandom);
            end
            if (!in_b.valid || acc_b) begin
                for (int l = 0; l < 4; l++)
                    s[l*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                in_b.valid = 1'($urandom_range(0, 1));
                in_b.data = {$urandom, $urandom, $urandom, $urandom}; in_b.strb = s;
            end
            out_a.ready = ($urandom_range(0, 3) != 0);
            out_b.ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc_a = in_a.valid && in_a.ready;
            acc_b = in_b.valid && in_b.ready;
            tick();
        end
        in_a.valid = 0; in_b.valid = 0; out_a.ready = 1; out_b.ready = 1;
        repeat (10) tick();
        chk("rand_sb_a_empty", sb_a.size(), 0);
        chk("rand_sb_b_empty", sb_b.size(), 0);

        // Synchronous reset dropped between edges while full.
        out_a.ready = 0;
        in_a.valid = 1; in_a.data = 64'h66666666_55555555; in_a.strb = 8'h7E;
        tick(); in_a.valid = 0;
        @(negedge clk); #2 rst_n = 0;
        #1 chk("srst_before_edge", {out_a.valid, out_a.data, out_a.strb, busy_a}, {1'b1, 32'h55555555, 4'hE, 1'b1});
        tick();
        chk("srst_after_edge", {out_a.valid, out_a.data, out_a.strb, busy_a, in_a.ready}, {1'b0, 32'h0, 4'h0, 1'b0, 1'b1});
        rst_n = 1; out_a.ready = 1; sb_a.delete();
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hwpe_stream_serialize_chunks.md
Name: hwpe_stream_serialize_chunks

Overview:
- Downstream companion of the N-to-1 stream merge stage.
- Consumes one wide stream word of NB_CHUNKS lanes and emits it as a sequence of narrow DATA_WIDTH_OUT words on a single stream, lane 0 first.
- Holds one wide word in an internal buffer. Optionally drops lanes whose strobe is all zero.
- Used where a merged wide word must reach a narrower consumer, e.g. a TCDM-width streamer.

Parameters:
NB_CHUNKS, 2, number of narrow lanes per wide input word (>=2)
DATA_WIDTH_OUT, 32, width of one lane and of stream_o.data (multiple of 8)
SKIP_EMPTY, 0, 1 = lanes with all-zero strobe are not emitted

Ports:
clk_i  input  1  clock
rst_ni  input  1  reset, synchronous, active-low
clear_i  input  1  synchronous soft clear, same effect as reset
stream_i  hwpe_stream_intf_stream.sink  data NB_CHUNKS*DATA_WIDTH_OUT, strb NB_CHUNKS*DATA_WIDTH_OUT/8  wide input stream
stream_o  hwpe_stream_intf_stream.source  data DATA_WIDTH_OUT, strb DATA_WIDTH_OUT/8  narrow output stream
busy_o  output  1  high while a wide word is held (full_q)

Behaviour:
- One clock. Reset is synchronous and active-low: all state changes only on the rising edge of clk_i while rst_ni=0. clear_i behaves identically and has priority over any handshake in the same cycle.
- State:
  - data_q: wide data register.
  - strb_q: wide strobe register.
  - full_q: 1 bit.
  - idx_q: $clog2(NB_CHUNKS) bits.
- Reset/clear values:
  - data_q, strb_q, idx_q = 0; full_q = 0.
  - Hence stream_o.valid=0, stream_o.data=0, stream_o.strb=0, busy_o=0, stream_i.ready=1.
- Output mapping:
  - stream_o.valid = full_q.
  - stream_o.data = lane idx_q of data_q, bits [(idx_q+1)*DATA_WIDTH_OUT-1 : idx_q*DATA_WIDTH_OUT].
  - stream_o.strb = lane idx_q of strb_q.
- Lane selection:
  - next_idx = first lane index > idx_q to be emitted. With SKIP_EMPTY=0 this is idx_q+1. With SKIP_EMPTY=1 it is the first index > idx_q whose strobe lane is nonzero.
  - last = no such lane exists.
  - first_idx(w) = first lane of word w to emit: 0 if SKIP_EMPTY=0, else the lowest lane of w with nonzero strobe.
  - If SKIP_EMPTY=1 and all lanes of w have zero strobe, w is "empty".
- Upstream ready:
  - stream_i.ready = ~full_q | (stream_o.ready & last).
  - This is a combinational path from stream_o.ready and is required for back-to-back throughput.
- Per-cycle update (no reset/clear), output handshake oh = stream_o.valid & stream_o.ready, input handshake ih = stream_i.valid & stream_i.ready:
  - ih, word not empty: load data_q/strb_q; idx_q = first_idx; full_q = 1. This covers both the empty-buffer case and the last-lane-consumed case.
  - ih, empty word: word is discarded. full_q = 0 if oh&last or buffer was empty; no output produced for it.
  - oh & ~last: idx_q = next_idx; full_q stays 1.
  - oh & last & ~ih: full_q = 0; idx_q = 0.
  - No handshake: all state holds. stream_o.data/strb/valid are stable under backpressure (AXI-stream rule: valid never drops without a handshake).
- Latency and throughput:
  - Input accepted at edge k gives first lane valid in cycle k+1.
  - With stream_o.ready=1 continuously, one narrow word per cycle, no bubble between wide words.
  - A wide word of E emitted lanes occupies E cycles.
- Reset or clear mid-word: remaining lanes are lost; the next cycle shows valid=0, ready=1.
- stream_i.valid asserted while full_q=1 and not last: the word is not accepted and upstream holds it.
- Protocol: the block must not lower stream_o.valid or change stream_o.data while stream_o.ready=0.

Test Plan:
- Basic order: NB_CHUNKS=2, push data=0xBBBB_BBBB_AAAA_AAAA, strb=0xFF, stream_o.ready=1 -> cycle+1 data=0xAAAA_AAAA strb=0xF; cycle+2 data=0xBBBB_BBBB; stream_i.ready=1 in cycle+2.
- Back-to-back: three wide words pushed continuously with ready=1 -> six consecutive narrow valid cycles, no bubble, correct lane order.
- Backpressure: hold stream_o.ready=0 for 3 cycles after first lane valid -> valid=1 and data=0xAAAA_AAAA stable, stream_i.ready=0; release -> lanes emitted in order, nothing lost or duplicated.
- Skip: SKIP_EMPTY=1, NB_CHUNKS=4, strb=0x0F0F -> only lanes 0 and 2 emitted. Then strb=0x0000 -> accepted in one cycle, no output valid. Then strb=0xF000 -> only lane 3 emitted.
- Clear mid-word: clear_i=1 for one cycle after lane 0 of a 2-lane word -> next cycle valid=0, busy_o=0, stream_i.ready=1; lane 1 never appears.
- Sync reset: drop rst_ni between clock edges while full -> outputs unchanged until the next rising edge, then valid=0, data=0, strb=0.
